// File: rtl/per2apb_bridge.sv
// per2apb_bridge: single-outstanding per-protocol slave to APB3 master bridge.
// Optional ACCESS-phase timeout abort enabled by defining PER2APB_TIMEOUT_EN.
module per2apb_bridge #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_slave_req_i,
  output logic                      per_slave_gnt_o,
  input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
  input  logic                      per_slave_we_i,
  input  logic [31:0]               per_slave_wdata_i,
  input  logic [3:0]                per_slave_be_i,
  input  logic [ID_WIDTH-1:0]       per_slave_id_i,
  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [31:0]               per_slave_r_rdata_o,
  output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic we_q, opc_q;
  logic [ID_WIDTH-1:0] id_q, rid_q;
  logic accept, be_err, done, timeout;
  assign accept = state == IDLE && per_slave_req_i;
  // APB3 has no strobes, so partial writes are refused without a bus transfer
  assign be_err = per_slave_we_i && per_slave_be_i != 4'hF;
  assign done   = state == ACCESS && (PREADY || timeout);
`ifdef PER2APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) > 8 ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !PREADY) cnt <= cnt + 1'b1;
  assign timeout = !PREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (be_err ? RESP : SETUP) : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = done ? RESP : ACCESS;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      id_q    <= '0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
      rid_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= APB_ADDR_WIDTH'(per_slave_add_i);
        wdata_q <= per_slave_wdata_i;
        we_q    <= per_slave_we_i;
        id_q    <= per_slave_id_i;
      end
      if (accept && be_err) begin
        rdata_q <= '0;
        opc_q   <= 1'b1;
        rid_q   <= per_slave_id_i;
      end
      if (done) begin
        rdata_q <= PREADY ? (we_q ? 32'h0 : PRDATA) : 32'hDEAD_BEEF;
        opc_q   <= PREADY ? PSLVERR : 1'b1;
        rid_q   <= id_q;
      end
    end
  end
  assign per_slave_gnt_o     = accept && rst_ni;
  assign per_slave_r_valid_o = state == RESP;
  assign per_slave_r_opc_o   = opc_q;
  assign per_slave_r_rdata_o = rdata_q;
  assign per_slave_r_id_o    = rid_q;
  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;
  assign PWRITE  = we_q;
  assign PSEL    = state == SETUP || state == ACCESS;
  assign PENABLE = state == ACCESS;
endmodule

// File: tb/tb_per2apb_bridge.sv
// tb_per2apb_bridge: directed self-checking bench for per2apb_bridge.
module tb_per2apb_bridge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] add = '0, wdata = '0, prdata = '0;
  logic [3:0] be = 4'hF;
  logic [7:0] id = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  logic gnt, r_valid, r_opc, pwrite, psel, penable;
  logic [31:0] r_rdata, paddr, pwdata;
  logic [7:0] r_id;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  per2apb_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_gnt_o(gnt), .per_slave_add_i(add),
    .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_id_i(id), .per_slave_r_valid_o(r_valid), .per_slave_r_opc_o(r_opc),
    .per_slave_r_rdata_o(r_rdata), .per_slave_r_id_o(r_id),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] i);
    req = 1'b1; we = w; add = a; wdata = d; be = b; id = i;
    #1;
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", r_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    // zero-wait read
    pready = 1'b1; prdata = 32'h1234_5678;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 8'h5A);
    chk("rd_gnt", gnt, 1);
    chk("rd_psel_T", psel, 0);
    tick; req = 1'b0; #1;
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_pen", penable, 0);
    chk("rd_setup_gnt", gnt, 0);
    tick;
    chk("rd_acc_psel", psel, 1);
    chk("rd_acc_pen", penable, 1);
    chk("rd_acc_paddr", paddr, 32'h10);
    chk("rd_acc_pwrite", pwrite, 0);
    tick;
    chk("rd_rvalid", r_valid, 1);
    chk("rd_rdata", r_rdata, 32'h1234_5678);
    chk("rd_opc", r_opc, 0);
    chk("rd_rid", r_id, 8'h5A);
    chk("rd_resp_psel", psel, 0);
    tick;
    chk("rd_rvalid_pulse", r_valid, 0);
    chk("rd_rdata_hold", r_rdata, 32'h1234_5678);
    // write with three wait states
    pready = 1'b0;
    issue(1'b1, 32'h1A10_0004, 32'hCAFE_F00D, 4'hF, 8'h21);
    chk("wr_gnt", gnt, 1);
    tick; req = 1'b0; #1;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_pwrite", pwrite, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("wr_acc_pen", penable, 1);
      chk("wr_acc_paddr", paddr, 32'h1A10_0004);
      chk("wr_acc_pwdata", pwdata, 32'hCAFE_F00D);
      chk("wr_acc_rvalid", r_valid, 0);
      pready = (i == 3);
      tick;
    end
    pready = 1'b0;
    chk("wr_rvalid", r_valid, 1);
    chk("wr_opc", r_opc, 0);
    chk("wr_rdata", r_rdata, 0);
    chk("wr_rid", r_id, 8'h21);
    tick;
    // partial write refused without APB traffic
    issue(1'b1, 32'h0000_0020, 32'h1111_2222, 4'h3, 8'h33);
    chk("be_gnt", gnt, 1);
    chk("be_psel_T", psel, 0);
    tick; req = 1'b0; #1;
    chk("be_rvalid", r_valid, 1);
    chk("be_psel", psel, 0);
    chk("be_opc", r_opc, 1);
    chk("be_rdata", r_rdata, 0);
    chk("be_rid", r_id, 8'h33);
    tick;
    // read with slave error; a request during RESP waits for IDLE
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hAAAA_5555;
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 8'h77);
    tick; req = 1'b0; #1;
    tick;
    tick;
    issue(1'b0, 32'h0000_0044, 32'h0, 4'hF, 8'h78);
    chk("err_rvalid", r_valid, 1);
    chk("err_opc", r_opc, 1);
    chk("err_rid", r_id, 8'h77);
    chk("err_gnt_in_resp", gnt, 0);
    tick;
    chk("err_gnt_after", gnt, 1);
    pslverr = 1'b0; prdata = 32'h0BAD_F00D;
    tick; req = 1'b0;
    tick;
    tick;
    chk("err2_rvalid", r_valid, 1);
    chk("err2_opc", r_opc, 0);
    chk("err2_rdata", r_rdata, 32'h0BAD_F00D);
    tick;
    // back-to-back with req held
    issue(1'b0, 32'h0000_0080, 32'h0, 4'hF, 8'h10);
    for (int c = 0; c < 12; c++) begin
      chk("b2b_gnt", gnt, (c % 4) == 0);
      chk("b2b_rvalid", r_valid, (c % 4) == 3);
      if (c % 4 == 3) chk("b2b_rid", r_id, 8'h10 + c / 4);
      tick;
      if (c % 4 == 0) id = id + 8'h1;
      #1;
    end
    req = 1'b0;
`ifdef PER2APB_TIMEOUT_EN
    // slave never ready: abort after 16 ACCESS cycles
    pready = 1'b0;
    issue(1'b0, 32'h0000_00C0, 32'h0, 4'hF, 8'h99);
    tick; req = 1'b0; #1;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("to_pen", penable, 1);
      chk("to_rvalid_wait", r_valid, 0);
      tick;
    end
    chk("to_rvalid", r_valid, 1);
    chk("to_psel", psel, 0);
    chk("to_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("to_opc", r_opc, 1);
    chk("to_rid", r_id, 8'h99);
    tick;
`endif
    // reset pulled mid-ACCESS
    pready = 1'b0;
    issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, 8'hE1);
    tick; req = 1'b0; #1;
    tick;
    tick;
    chk("mid_psel_before", psel, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_psel", psel, 0);
    chk("mid_penable", penable, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mid_rvalid", r_valid, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rvalid", r_valid, 0);
      chk("post_psel", psel, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
